// File: rtl/vga_timing_pkg.sv
// Shared timing constants, phase type and width helper for the VGA timing block.
// Latency: n/a (package only).
// Backpressure: n/a.
package vga_timing_pkg;

  // 640x480 @ 60 Hz timing, in pixels (horizontal) and lines (vertical)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CLK_DIV  = 2;

  // Position of an axis within its line/frame
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  // Bits needed to count 0..total-1 (at least one bit)
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA axis: wrapping position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Latency: count/phase update on the CLK edge where adv is high; wrap is combinational.
// Backpressure: none, advances only when told to.
// Ports: CLK, RST (async, active-low); adv = step one position;
//        count = position, phase/phase_nxt = current/next phase, wrap = this step returns to 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FP_LEN     = DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BP_LEN     = DEF_H_BP,
  parameter int W          = cnt_width(ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         adv,
  output logic [W-1:0] count,
  output phase_t       phase,
  output phase_t       phase_nxt,
  output logic         wrap
);

  localparam int TOTAL = ACTIVE_LEN + FP_LEN + SYNC_LEN + BP_LEN;

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] AT_FRONT = W'(ACTIVE_LEN);
  localparam logic [W-1:0] AT_SYNC  = W'(ACTIVE_LEN + FP_LEN);
  localparam logic [W-1:0] AT_BACK  = W'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

  logic [W-1:0] count_nxt;

  assign wrap = adv && (count == LAST);

  // Phase is a function of the position being entered. Later boundaries are
  // tested first so a zero-length region is skipped rather than entered.
  always_comb begin
    count_nxt = count;
    phase_nxt = phase;
    if (adv) begin
      count_nxt = wrap ? '0 : count + W'(1);
      if (count_nxt == '0)
        phase_nxt = ACTIVE;
      else if (count_nxt == AT_BACK)
        phase_nxt = BACK;
      else if (count_nxt == AT_SYNC)
        phase_nxt = SYNC;
      else if (count_nxt == AT_FRONT)
        phase_nxt = FRONT;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
      phase <= ACTIVE;
    end else begin
      count <= count_nxt;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel strobe, col/row position, syncs, blanking, frame pulse.
// Latency: all position/sync outputs are flops updated on the same pix_en edge.
// Backpressure: none, free-running from CLK.
// Ports: CLK, RST (async, active-low); col,row (32-bit zero-extended position);
//        vnotactive (outside visible area); hsync,vsync (active-low);
//        pix_en (one-CLK pixel strobe); frame_start (one-CLK pulse at frame wrap);
//        frame_cnt (16-bit frame counter, only when VGA_FRAME_CNT_EN is defined).
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV   // must be 1 or more
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] col,
  output logic [31:0] row,
  output logic        vnotactive,
  output logic        hsync,
  output logic        vsync,
  output logic        pix_en,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);
  localparam int DIV_W   = cnt_width(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [HW-1:0]    h_count;
  logic [VW-1:0]    v_count;
  phase_t           h_phase, h_phase_nxt;
  phase_t           v_phase, v_phase_nxt;
  logic             h_wrap, v_wrap;

  // With CLK_DIV=1 the divider sits at 0 == DIV_LAST, so pix_en stays high.
  assign pix_en = (div == DIV_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      div <= '0;
    else
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
  end

  vga_axis_counter #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP),
    .W          (HW)
  ) u_h_axis (
    .CLK       (CLK),
    .RST       (RST),
    .adv       (pix_en),
    .count     (h_count),
    .phase     (h_phase),
    .phase_nxt (h_phase_nxt),
    .wrap      (h_wrap)
  );

  // Rows step on the same edge the line wraps
  vga_axis_counter #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP),
    .W          (VW)
  ) u_v_axis (
    .CLK       (CLK),
    .RST       (RST),
    .adv       (h_wrap),
    .count     (v_count),
    .phase     (v_phase),
    .phase_nxt (v_phase_nxt),
    .wrap      (v_wrap)
  );

  assign col = 32'(h_count);
  assign row = 32'(v_count);

  // Sync/blank flops are loaded from the next phase, so they switch on the
  // same edge as the counters; they only need reloading at a phase change.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vnotactive  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= v_wrap;
      if ((h_phase_nxt != h_phase) || (v_phase_nxt != v_phase)) begin
        hsync      <= (h_phase_nxt != SYNC);
        vsync      <= (v_phase_nxt != SYNC);
        vnotactive <= (h_phase_nxt != ACTIVE) || (v_phase_nxt != ACTIVE);
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      frame_cnt <= '0;
    else if (v_wrap)
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (default 640x480 /2, small geometry /3,
// small geometry /1) checked every cycle against an arithmetic raster model,
// plus scenario tasks for reset, blanking, line/frame wrap and mid-frame reset.
module tb_vga_timing;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  localparam int NDUT = 3;
  localparam int CD [NDUT] = '{2, 3, 1};
  localparam int HA [NDUT] = '{640, 20, 10};
  localparam int HF [NDUT] = '{16, 3, 2};
  localparam int HS [NDUT] = '{96, 4, 3};
  localparam int HB [NDUT] = '{48, 5, 2};
  localparam int VA [NDUT] = '{480, 6, 4};
  localparam int VF [NDUT] = '{10, 2, 1};
  localparam int VS [NDUT] = '{2, 2, 1};
  localparam int VB [NDUT] = '{33, 3, 2};

  logic [31:0] col [NDUT];
  logic [31:0] row [NDUT];
  logic        vna [NDUT];
  logic        hs  [NDUT];
  logic        vs  [NDUT];
  logic        pe  [NDUT];
  logic        fs  [NDUT];
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fcnt [NDUT];
`endif

  vga_timing #(
    .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
    .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]), .CLK_DIV(CD[0])
  ) u_d0 (
    .CLK(CLK), .RST(RST), .col(col[0]), .row(row[0]), .vnotactive(vna[0]),
    .hsync(hs[0]), .vsync(vs[0]), .pix_en(pe[0]),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fcnt[0]),
`endif
    .frame_start(fs[0])
  );

  vga_timing #(
    .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
    .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]), .CLK_DIV(CD[1])
  ) u_d1 (
    .CLK(CLK), .RST(RST), .col(col[1]), .row(row[1]), .vnotactive(vna[1]),
    .hsync(hs[1]), .vsync(vs[1]), .pix_en(pe[1]),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fcnt[1]),
`endif
    .frame_start(fs[1])
  );

  vga_timing #(
    .H_ACTIVE(HA[2]), .H_FP(HF[2]), .H_SYNC(HS[2]), .H_BP(HB[2]),
    .V_ACTIVE(VA[2]), .V_FP(VF[2]), .V_SYNC(VS[2]), .V_BP(VB[2]), .CLK_DIV(CD[2])
  ) u_d2 (
    .CLK(CLK), .RST(RST), .col(col[2]), .row(row[2]), .vnotactive(vna[2]),
    .hsync(hs[2]), .vsync(vs[2]), .pix_en(pe[2]),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt(fcnt[2]),
`endif
    .frame_start(fs[2])
  );

  typedef struct packed {
    logic [31:0] col;
    logic [31:0] row;
    logic        vna;
    logic        hs;
    logic        vs;
    logic        pe;
    logic        fs;
  } obs_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs after n CLK edges since reset release, derived purely
  // from the pixel index n / CLK_DIV.
  function automatic obs_t model(input int i, input int n);
    obs_t o;
    int ht, vt, p, c, r;
    ht = HA[i] + HF[i] + HS[i] + HB[i];
    vt = VA[i] + VF[i] + VS[i] + VB[i];
    p = n / CD[i];
    c = p % ht;
    r = (p / ht) % vt;
    o.col = 32'(c);
    o.row = 32'(r);
    o.vna = (c >= HA[i]) || (r >= VA[i]);
    o.hs  = !((c >= HA[i] + HF[i]) && (c < HA[i] + HF[i] + HS[i]));
    o.vs  = !((r >= VA[i] + VF[i]) && (r < VA[i] + VF[i] + VS[i]));
    o.pe  = ((n % CD[i]) == CD[i] - 1);
    o.fs  = (n > 0) && ((n % CD[i]) == 0) && ((p % (ht * vt)) == 0);
    return o;
  endfunction

  // Scoreboard: expectation pushed on each driving edge, compared at the
  // following falling edge.
  obs_t sbq [NDUT][$];
  int   edge_n [NDUT] = '{default: 0};

  always @(posedge CLK) begin
    for (int i = 0; i < NDUT; i++) begin
      if (RST) edge_n[i] = edge_n[i] + 1;
      else     edge_n[i] = 0;
      sbq[i].push_back(model(i, edge_n[i]));
    end
  end

  obs_t sb_e, sb_a;
  always @(negedge CLK) begin
    for (int j = 0; j < NDUT; j++) begin
      if (sbq[j].size() > 0) begin
        sb_e = sbq[j].pop_front();
        if (!RST) sb_e = model(j, 0);
        sb_a = {col[j], row[j], vna[j], hs[j], vs[j], pe[j], fs[j]};
        n_cmp++;
        if (sb_a !== sb_e) begin
          n_bad++;
          $display("FAIL sb_dut%0d @%0t: got col=%0d row=%0d vna=%b hs=%b vs=%b pe=%b fs=%b, expected col=%0d row=%0d vna=%b hs=%b vs=%b pe=%b fs=%b",
                   j, $time, sb_a.col, sb_a.row, sb_a.vna, sb_a.hs, sb_a.vs, sb_a.pe, sb_a.fs,
                   sb_e.col, sb_e.row, sb_e.vna, sb_e.hs, sb_e.vs, sb_e.pe, sb_e.fs);
        end
      end
    end
  end

  task automatic test_reset();
    obs_t a, e;
    logic exp_pe0 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int   exp_c0  [5] = '{0, 0, 1, 1, 2};
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < NDUT; i++) begin
      a = {col[i], row[i], vna[i], hs[i], vs[i], pe[i], fs[i]};
      e = {32'd0, 32'd0, 1'b0, 1'b1, 1'b1, (CD[i] == 1), 1'b0};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL reset_dut%0d: got %h, expected %h", i, a, e);
      end
    end
    RST = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge CLK);
      n_cmp++;
      if ({pe[0], col[0]} !== {exp_pe0[k], 32'(exp_c0[k])}) begin
        n_bad++;
        $display("FAIL div2_step%0d: got pe=%b col=%0d, expected pe=%b col=%0d",
                 k, pe[0], col[0], exp_pe0[k], exp_c0[k]);
      end
      n_cmp++;
      if ({pe[2], col[2]} !== {1'b1, 32'(k)}) begin
        n_bad++;
        $display("FAIL div1_step%0d: got pe=%b col=%0d, expected pe=1 col=%0d", k, pe[2], col[2], k);
      end
    end
  endtask

  task automatic test_vnotactive();
    int k;
    k = 0;
    while (col[0] != 639 && k < 4000) begin @(negedge CLK); k++; end
    n_cmp++;
    if ({col[0], row[0], vna[0]} !== {32'd639, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL vna_c639: got col=%0d row=%0d vna=%b, expected col=639 row=0 vna=0", col[0], row[0], vna[0]);
    end
    k = 0;
    while (col[0] != 640 && k < 10) begin @(negedge CLK); k++; end
    n_cmp++;
    if ({col[0], vna[0]} !== {32'd640, 1'b1}) begin
      n_bad++;
      $display("FAIL vna_c640: got col=%0d vna=%b, expected col=640 vna=1", col[0], vna[0]);
    end
    k = 0;
    while (!(row[1] == 5 && col[1] == 19) && k < 3000) begin @(negedge CLK); k++; end
    n_cmp++;
    if ({row[1], col[1], vna[1]} !== {32'd5, 32'd19, 1'b0}) begin
      n_bad++;
      $display("FAIL vna_lastvis: got row=%0d col=%0d vna=%b, expected row=5 col=19 vna=0", row[1], col[1], vna[1]);
    end
    k = 0;
    while (!(row[1] == 6 && col[1] == 0) && k < 3000) begin @(negedge CLK); k++; end
    n_cmp++;
    if ({row[1], col[1], vna[1]} !== {32'd6, 32'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL vna_row_va: got row=%0d col=%0d vna=%b, expected row=6 col=0 vna=1", row[1], col[1], vna[1]);
    end
  endtask

  task automatic test_line_wrap();
    int k, first, cnt;
    k = 0;
    while (!(row[0] == 5 && col[0] == 799 && pe[0]) && k < 20000) begin @(negedge CLK); k++; end
    @(negedge CLK);
    n_cmp++;
    if ({col[0], row[0]} !== {32'd0, 32'd6}) begin
      n_bad++;
      $display("FAIL line_wrap: got col=%0d row=%0d, expected col=0 row=6", col[0], row[0]);
    end
    first = -1; cnt = 0; k = 0;
    while (col[0] < 752 && k < 3000) begin
      @(negedge CLK); k++;
      if (pe[0] && !hs[0]) begin
        if (first < 0) first = int'(col[0]);
        cnt++;
      end
    end
    n_cmp++;
    if (first != 656) begin
      n_bad++;
      $display("FAIL hsync_start: got col=%0d, expected col=656", first);
    end
    n_cmp++;
    if (cnt != 96) begin
      n_bad++;
      $display("FAIL hsync_width: got %0d pixels, expected 96", cnt);
    end
  endtask

  task automatic test_frame_wrap();
    int k, gap, vrows, vfirst;
    k = 0;
    while (!fs[1] && k < 3000) begin @(negedge CLK); k++; end
    n_cmp++;
    if ({fs[1], row[1], col[1]} !== {1'b1, 32'd0, 32'd0}) begin
      n_bad++;
      $display("FAIL frame_pos: got fs=%b row=%0d col=%0d, expected fs=1 row=0 col=0", fs[1], row[1], col[1]);
    end
    @(negedge CLK);
    gap = 1;
    n_cmp++;
    if (fs[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_pulse_width: got fs=%b one CLK later, expected 0", fs[1]);
    end
    vrows = 0; vfirst = -1;
    while (!fs[1] && gap < 3000) begin
      if (pe[1] && col[1] == 0 && !vs[1]) begin
        if (vfirst < 0) vfirst = int'(row[1]);
        vrows++;
      end
      @(negedge CLK); gap++;
    end
    n_cmp++;
    if (gap != 1248) begin
      n_bad++;
      $display("FAIL frame_spacing: got %0d CLK, expected 1248", gap);
    end
    n_cmp++;
    if (vrows != 2 || vfirst != 8) begin
      n_bad++;
      $display("FAIL vsync_rows: got %0d rows from row %0d, expected 2 rows from row 8", vrows, vfirst);
    end
  endtask

  task automatic test_mid_reset();
    int k, viol;
    obs_t a, e;
    k = 0;
    while (!(row[1] == 8 && col[1] == 24) && k < 3000) begin @(negedge CLK); k++; end
    #2 RST = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      a = {col[i], row[i], vna[i], hs[i], vs[i], pe[i], fs[i]};
      e = {32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL midreset_dut%0d: got %h, expected %h", i, a, e);
      end
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    viol = 0; k = 0;
    while (col[0] != 656 && k < 2000) begin
      @(negedge CLK); k++;
      if (col[0] != 656 && (!hs[0] || !vs[0] || row[0] != 0)) viol++;
    end
    n_cmp++;
    if (viol != 0) begin
      n_bad++;
      $display("FAIL midreset_nosync: got %0d cycles with sync low or row!=0, expected 0", viol);
    end
    n_cmp++;
    if ({col[0], hs[0]} !== {32'd656, 1'b0}) begin
      n_bad++;
      $display("FAIL midreset_hsync: got col=%0d hs=%b, expected col=656 hs=0", col[0], hs[0]);
    end
  endtask

`ifdef VGA_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int k, nf;
    nf = 0; k = 0;
    while (nf < 3 && k < 6000) begin
      @(negedge CLK); k++;
      if (fs[1]) nf++;
    end
    n_cmp++;
    if (fcnt[1] !== 16'd3) begin
      n_bad++;
      $display("FAIL frame_cnt3: got %0d, expected 3", fcnt[1]);
    end
    @(negedge CLK);
    force u_d1.frame_cnt = 16'hFFFF;
    @(negedge CLK);
    release u_d1.frame_cnt;
    k = 0;
    while (!fs[1] && k < 3000) begin @(negedge CLK); k++; end
    n_cmp++;
    if ({fs[1], fcnt[1]} !== {1'b1, 16'd0}) begin
      n_bad++;
      $display("FAIL frame_cnt_wrap: got fs=%b cnt=%0d, expected fs=1 cnt=0", fs[1], fcnt[1]);
    end
  endtask
`endif

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge CLK);
    test_reset();
    test_vnotactive();
    test_line_wrap();
    test_frame_wrap();
    test_mid_reset();
`ifdef VGA_FRAME_CNT_EN
    test_frame_cnt();
`endif
    repeat (4) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48: horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33: vertical porch and sync in lines.
REQ-005 SHALL have parameter CLK_DIV, default 2, CLK cycles per pixel; legal range is 1 or more.
REQ-006 SHALL have port CLK, input, 1 bit: clock.
REQ-007 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port col, output, 32 bits: horizontal pixel index.
REQ-009 SHALL have port row, output, 32 bits: vertical line index.
REQ-010 SHALL have port vnotactive, output, 1 bit: high when the current pixel is outside the visible area.
REQ-011 SHALL have port hsync, output, 1 bit: active-low horizontal sync.
REQ-012 SHALL have port vsync, output, 1 bit: active-low vertical sync.
REQ-013 SHALL have port pix_en, output, 1 bit: one-CLK pixel strobe.
REQ-014 SHALL have port frame_start, output, 1 bit: one-CLK pulse at frame wrap.

Function
REQ-015 SHALL run a divider counter 0..CLK_DIV-1 and assert pix_en for one CLK when the divider equals CLK_DIV-1; with CLK_DIV=1, pix_en SHALL be constantly high after reset.
REQ-016 SHALL advance col only on a CLK edge with pix_en high; col SHALL run from 0 to H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, 800 by default), then wrap to 0.
REQ-017 SHALL increment row on the same edge that col wraps; row SHALL run from 0 to V_TOTAL-1 (525 by default), then wrap to 0.
REQ-018 SHALL track a horizontal phase FSM ACTIVE->FRONT->SYNC->BACK->ACTIVE, with transitions at col = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC and 0; a vertical FSM SHALL follow the same pattern on row.
REQ-019 SHALL drive hsync low exactly while the horizontal FSM is in SYNC, i.e. col 656..751 by default.
REQ-020 SHALL drive vsync low exactly while the vertical FSM is in SYNC, i.e. row 490..491 by default; vsync SHALL be independent of col.
REQ-021 SHALL drive vnotactive = (col >= H_ACTIVE) OR (row >= V_ACTIVE).
REQ-022 SHALL register col, row, vnotactive, hsync and vsync so that they change on the same CLK edge; no output SHALL lag another.
REQ-023 SHALL assert frame_start for exactly one CLK, on the edge where {row,col} becomes {0,0} from {V_TOTAL-1,H_TOTAL-1}.
REQ-024 SHALL hold all outputs stable between pix_en strobes, except pix_en and frame_start.
REQ-025 SHALL zero-extend col and row to 32 bits; upper bits SHALL always be 0.

Reset
REQ-026 On RST low, SHALL immediately set col=0, row=0, divider=0, hsync=1, vsync=1, vnotactive=0, pix_en=0 (1 if CLK_DIV=1), frame_start=0, and both FSMs to ACTIVE.
REQ-027 SHALL restart counting from (0,0) on the first CLK after RST deasserts, including when reset is asserted mid-line or mid-frame; no partial sync pulse SHALL follow.

Configuration
REQ-028 With macro VGA_FRAME_CNT_EN defined, SHALL add output frame_cnt, 16 bits, reset to 0, incremented on each frame_start and wrapping from 65535 to 0.
REQ-029 Without VGA_FRAME_CNT_EN, the frame_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 SHALL place the default timing constants and the 2-bit phase typedef (ACTIVE, FRONT, SYNC, BACK) in the shared package vga_timing_pkg.
REQ-031 SHALL implement each axis as sub-module vga_axis_counter, instantiated twice (horizontal, vertical), with parameters for active, front porch, sync and back porch, inputs for advance, and outputs for count, phase and wrap.

Verification
REQ-032 Reset, CLK_DIV=2: release RST -> col increments every 2 CLK; pix_en toggles 0,1,0,1.
REQ-033 Line wrap: at col=799, row=5, next pix_en -> col=0, row=6 on the same edge; hsync low for exactly 96 pixels starting at col=656.
REQ-034 Frame wrap: at row=524, col=799 -> row=0, col=0, frame_start high 1 CLK; vsync low only during rows 490-491; spacing between frame_start pulses = 420000 pixels = 840000 CLK.
REQ-035 vnotactive: col=639, row=0 -> 0; col=640 -> 1; row=480, col=0 -> 1.
REQ-036 Mid-frame reset: assert RST at row=300, col=700 -> outputs match REQ-026 immediately; after release, the count restarts at 0 and hsync stays high until col=656.
REQ-037 With VGA_FRAME_CNT_EN: after 3 frames -> frame_cnt=3; preload 65535 via force -> next frame_start gives 0.
